pipeline_hazard_ctrl: RTL

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_pkg.sv | 38 +++
 rtl/pipeline_hazard_ctrl_if.sv | 52 +++++
 rtl/pipeline_hazard_ctrl_forward.sv | 27 ++
 rtl/pipeline_hazard_ctrl.sv | 112 +++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared types for the pipeline hazard controller: multiply/divide FSM states,
// forwarding-mux encodings and the busy-counter width.
package pipeline_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF = 2'b00;
    localparam fwd_sel_t FWD_W  = 2'b01;
    localparam fwd_sel_t FWD_M  = 2'b10;

    // The M stage carries the younger result, so it beats W on a double match.
    function automatic fwd_sel_t fwd_sel(
        input logic       reg_write_m,
        input logic [4:0] write_reg_m,
        input logic       reg_write_w,
        input logic [4:0] write_reg_w,
        input logic [4:0] src
    );
        fwd_sel_t sel;
        if (reg_write_m && (write_reg_m != 5'd0) && (write_reg_m == src)) begin
            sel = FWD_M;
        end else if (reg_write_w && (write_reg_w != 5'd0) && (write_reg_w == src)) begin
            sel = FWD_W;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-to-hazard-unit bundle: stage register numbers and control bits in,
// stall/flush enables and forwarding selects out.
interface pipeline_hazard_ctrl_if;
    import pipeline_pkg::*;

    logic [4:0] rs_d;
    logic [4:0] rt_d;
    logic [4:0] rs_e;
    logic [4:0] rt_e;
    logic [4:0] write_reg_e;
    logic [4:0] write_reg_m;
    logic [4:0] write_reg_w;
    logic       reg_write_e;
    logic       reg_write_m;
    logic       reg_write_w;
    logic       mem_to_reg_e;
    logic       mem_to_reg_m;
    logic       mem_write_m;
    logic       branch_d;
    logic       pc_src_d;
    logic       md_op_e;
    logic       mem_ready;

    logic       haz_enable_f;
    logic       haz_enable_d;
    logic       haz_enable_e;
    logic       haz_enable_m;
    logic       haz_clr_d;
    logic       haz_clr_e;
    logic       md_busy;
    fwd_sel_t   fwd_a_e;
    fwd_sel_t   fwd_b_e;
    logic       fwd_a_d;
    logic       fwd_b_d;

    modport master (
        output rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w,
               reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_to_reg_m,
               mem_write_m, branch_d, pc_src_d, md_op_e, mem_ready,
        input  haz_enable_f, haz_enable_d, haz_enable_e, haz_enable_m,
               haz_clr_d, haz_clr_e, md_busy, fwd_a_e, fwd_b_e, fwd_a_d, fwd_b_d
    );

    modport slave (
        input  rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w,
               reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_to_reg_m,
               mem_write_m, branch_d, pc_src_d, md_op_e, mem_ready,
        output haz_enable_f, haz_enable_d, haz_enable_e, haz_enable_m,
               haz_clr_d, haz_clr_e, md_busy, fwd_a_e, fwd_b_e, fwd_a_d, fwd_b_d
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_forward.sv
// Combinational bypass selection for the E-stage ALU operands and the
// D-stage branch comparator.
module pipeline_forward
    import pipeline_pkg::*;
(
    input  logic [4:0] rs_d,
    input  logic [4:0] rt_d,
    input  logic [4:0] rs_e,
    input  logic [4:0] rt_e,
    input  logic [4:0] write_reg_m,
    input  logic [4:0] write_reg_w,
    input  logic       reg_write_m,
    input  logic       reg_write_w,
    output fwd_sel_t   fwd_a_e,
    output fwd_sel_t   fwd_b_e,
    output logic       fwd_a_d,
    output logic       fwd_b_d
);

    assign fwd_a_e = fwd_sel(reg_write_m, write_reg_m, reg_write_w, write_reg_w, rs_e);
    assign fwd_b_e = fwd_sel(reg_write_m, write_reg_m, reg_write_w, write_reg_w, rt_e);

    // The branch comparator only taps the M-stage ALU result.
    assign fwd_a_d = reg_write_m && (write_reg_m != 5'd0) && (write_reg_m == rs_d);
    assign fwd_b_d = reg_write_m && (write_reg_m != 5'd0) && (write_reg_m == rt_d);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard unit: load-use/branch/memory stalls, multi-cycle multiply/divide
// occupancy FSM and operand forwarding for a 5-stage pipeline.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int MD_LATENCY = 4
) (
    input logic                   clk,
    input logic                   rst_n,
    pipeline_hazard_ctrl_if.slave hz
);

    md_state_e        state_r;
    logic [CNT_W-1:0] cnt_r;

    logic     lw_stall_s;
    logic     br_stall_s;
    logic     mem_stall_s;
    logic     md_stall_s;
    fwd_sel_t fwd_a_e_s;
    fwd_sel_t fwd_b_e_s;
    logic     fwd_a_d_s;
    logic     fwd_b_d_s;

    pipeline_forward u_forward (
        .rs_d        (hz.rs_d),
        .rt_d        (hz.rt_d),
        .rs_e        (hz.rs_e),
        .rt_e        (hz.rt_e),
        .write_reg_m (hz.write_reg_m),
        .write_reg_w (hz.write_reg_w),
        .reg_write_m (hz.reg_write_m),
        .reg_write_w (hz.reg_write_w),
        .fwd_a_e     (fwd_a_e_s),
        .fwd_b_e     (fwd_b_e_s),
        .fwd_a_d     (fwd_a_d_s),
        .fwd_b_d     (fwd_b_d_s)
    );

    assign lw_stall_s  = hz.mem_to_reg_e && ((hz.rt_e == hz.rs_d) || (hz.rt_e == hz.rt_d));
    assign br_stall_s  = hz.branch_d &&
                         ((hz.reg_write_e  && ((hz.write_reg_e == hz.rs_d) || (hz.write_reg_e == hz.rt_d))) ||
                          (hz.mem_to_reg_m && ((hz.write_reg_m == hz.rs_d) || (hz.write_reg_m == hz.rt_d))));
    assign mem_stall_s = (hz.mem_to_reg_m || hz.mem_write_m) && !hz.mem_ready;
    assign md_stall_s  = (state_r == MD_BUSY) || ((state_r == IDLE) && hz.md_op_e);

    // Multiply/divide occupancy FSM; a memory stall freezes it along with the pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
        end else if (!mem_stall_s) begin
            case (state_r)
                IDLE: begin
                    if (hz.md_op_e) begin
                        if (MD_LATENCY > 2) begin
                            state_r <= MD_BUSY;
                            cnt_r   <= CNT_W'(MD_LATENCY - 2);
                        end else begin
                            state_r <= MD_DONE;
                        end
                    end
                end
                MD_BUSY: begin
                    cnt_r <= cnt_r - CNT_W'(1);
                    if (cnt_r == CNT_W'(1)) begin
                        state_r <= MD_DONE;
                    end
                end
                MD_DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Stall priority: a full freeze beats a bubble, which beats a branch flush.
    always_comb begin
        hz.haz_enable_f = 1'b0;
        hz.haz_enable_d = 1'b0;
        hz.haz_enable_e = 1'b0;
        hz.haz_enable_m = 1'b0;
        hz.haz_clr_d    = 1'b0;
        hz.haz_clr_e    = 1'b0;
        if (!rst_n) begin
            hz.haz_enable_f = 1'b0;
        end else if (mem_stall_s || md_stall_s) begin
            hz.haz_enable_f = 1'b0;
        end else if (lw_stall_s || br_stall_s) begin
            hz.haz_enable_e = 1'b1;
            hz.haz_enable_m = 1'b1;
            hz.haz_clr_e    = 1'b1;
        end else begin
            hz.haz_enable_f = 1'b1;
            hz.haz_enable_d = 1'b1;
            hz.haz_enable_e = 1'b1;
            hz.haz_enable_m = 1'b1;
            hz.haz_clr_d    = hz.pc_src_d;
        end
    end

    assign hz.md_busy = rst_n && md_stall_s;
    assign hz.fwd_a_e = rst_n ? fwd_a_e_s : FWD_RF;
    assign hz.fwd_b_e = rst_n ? fwd_b_e_s : FWD_RF;
    assign hz.fwd_a_d = rst_n && fwd_a_d_s;
    assign hz.fwd_b_d = rst_n && fwd_b_d_s;

endmodule
